serv_wb_timer: RTL and testbench

SERV_WB_TIMER -- requirements
Module: serv_wb_timer

---
 rtl/serv_wb_timer.sv | 111 +++++++++++
 tb/tb_serv_wb_timer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serv_wb_timer.sv
// serv_wb_timer: 64-bit mtime/mtimecmp timer behind a minimal Wishbone slave port.
// mtime advances once every DIV clocks. o_timer_irq is the registered result of mtime >= mtimecmp.
module serv_wb_timer #(
   parameter int unsigned DIV = 1
) (
   input  logic        clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_timer_irq
);

   typedef enum logic {S_IDLE = 1'b0, S_ACK = 1'b1} state_t;

   localparam logic [7:0] PRESC_LAST = 8'(DIV - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic        w_start;
   logic        w_wr;
   logic        w_tick;
   logic [1:0]  w_reg;
   logic [3:0]  w_lane_we;
   logic [7:0]  r_presc;
   logic [63:0] r_mtime;
   logic [63:0] r_mtimecmp;
   logic [63:0] w_mtime_inc;
   logic [63:0] w_mtime_next;
   logic [63:0] w_mtimecmp_next;
   logic [31:0] r_rdt;
   logic [31:0] w_rdata;
   logic        r_irq;
   logic        w_unused;

   assign w_unused = ^{i_wb_adr[31:4], i_wb_adr[1:0]};

   // A request is only accepted from IDLE, so ack can never repeat back to back.
   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_wb_cyc) begin
               w_state_next = S_ACK;
               w_start      = 1'b1;
            end
         end
         S_ACK:   w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   assign w_wr        = w_start & i_wb_we;
   assign w_reg       = i_wb_adr[3:2];
   assign w_lane_we   = {4{w_wr}} & i_wb_sel;
   assign w_tick      = (r_presc == PRESC_LAST);
   assign w_mtime_inc = r_mtime + {63'd0, w_tick};

   // Written bytes override the incremented value; all other bytes keep counting.
   genvar gi;
   for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_mtime_next[8*gi +: 8] = (w_lane_we[gi] && w_reg == 2'd0) ?
                                       i_wb_dat[8*gi +: 8] : w_mtime_inc[8*gi +: 8];
      assign w_mtime_next[32+8*gi +: 8] = (w_lane_we[gi] && w_reg == 2'd1) ?
                                          i_wb_dat[8*gi +: 8] : w_mtime_inc[32+8*gi +: 8];
      assign w_mtimecmp_next[8*gi +: 8] = (w_lane_we[gi] && w_reg == 2'd2) ?
                                          i_wb_dat[8*gi +: 8] : r_mtimecmp[8*gi +: 8];
      assign w_mtimecmp_next[32+8*gi +: 8] = (w_lane_we[gi] && w_reg == 2'd3) ?
                                             i_wb_dat[8*gi +: 8] : r_mtimecmp[32+8*gi +: 8];
   end

   always_comb begin
      w_rdata = r_mtime[31:0];
      case (w_reg)
         2'd0:    w_rdata = r_mtime[31:0];
         2'd1:    w_rdata = r_mtime[63:32];
         2'd2:    w_rdata = r_mtimecmp[31:0];
         default: w_rdata = r_mtimecmp[63:32];
      endcase
   end

   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_presc    <= 8'd0;
         r_mtime    <= 64'd0;
         r_mtimecmp <= '1;
         r_rdt      <= 32'd0;
         r_irq      <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_presc    <= w_tick ? 8'd0 : r_presc + 8'd1;
         r_mtime    <= w_mtime_next;
         r_mtimecmp <= w_mtimecmp_next;
         if (w_start) begin
            r_rdt <= w_rdata;
         end
         r_irq <= (r_mtime >= r_mtimecmp);
      end
   end

   assign o_wb_ack    = (r_state == S_ACK);
   assign o_wb_rdt    = r_rdt;
   assign o_timer_irq = r_irq;

endmodule

// File: tb/tb_serv_wb_timer.sv
// Testbench for serv_wb_timer: a DIV=1 and a DIV=4 instance share one bus.
// Read data goes through a scoreboard queue. The DIV=1 instance is also checked against a reference timer model.
`timescale 1ns/1ps
module tb_serv_wb_timer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat;
   logic [3:0]  sel;
   logic [31:0] rdt1, rdt4;
   logic        ack1, ack4, irq1, irq4;

   always #5 clk = ~clk;

   serv_wb_timer #(.DIV(1)) dut1 (
      .clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
      .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_timer_irq(irq1)
   );

   serv_wb_timer #(.DIV(4)) dut4 (
      .clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
      .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt4), .o_wb_ack(ack4), .o_timer_irq(irq4)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int edge_cnt = 0;    // rising edges seen with reset released
   int drive_edge = 0;  // edge_cnt when the latest request was driven
   logic prev_ack;

   // Reference timer for the DIV=1 instance
   logic [63:0] m_mtime, m_cmp, m_nt, m_nc;
   logic        m_irq, m_busy;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) begin
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      end
      return r;
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a);
      case (a[3:2])
         2'd0:    return m_mtime[31:0];
         2'd1:    return m_mtime[63:32];
         2'd2:    return m_cmp[31:0];
         default: return m_cmp[63:32];
      endcase
   endfunction

   always @(posedge clk) begin
      edge_cnt <= rst_n ? edge_cnt + 1 : 0;
      if (!rst_n) begin
         m_mtime <= 64'd0;
         m_cmp   <= 64'hFFFF_FFFF_FFFF_FFFF;
         m_irq   <= 1'b0;
         m_busy  <= 1'b0;
      end else begin
         m_nt = m_mtime + 64'd1;
         m_nc = m_cmp;
         if (!m_busy && cyc && we) begin
            case (adr[3:2])
               2'd0:    m_nt[31:0]  = merge(m_nt[31:0], dat, sel);
               2'd1:    m_nt[63:32] = merge(m_nt[63:32], dat, sel);
               2'd2:    m_nc[31:0]  = merge(m_nc[31:0], dat, sel);
               default: m_nc[63:32] = merge(m_nc[63:32], dat, sel);
            endcase
         end
         m_busy  <= !m_busy && cyc;
         m_irq   <= (m_mtime >= m_cmp);
         m_mtime <= m_nt;
         m_cmp   <= m_nc;
      end
   end

   typedef struct {
      logic [31:0] exp;
      bit          chk4;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          mode;  // 0 write, 1 constant expectation, 2 reference-model expectation
      logic [31:0] exp;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Advance to the next falling edge and run the per-cycle checks.
   task automatic step();
      @(negedge clk);
      chk("irq_vs_model", {63'd0, irq1}, {63'd0, m_irq});
      chk("ack_not_b2b", {63'd0, ack1 & prev_ack}, 64'd0);
      chk("ack_div_agree", {63'd0, ack4}, {63'd0, ack1});
      prev_ack = ack1;
   endtask

   task automatic bus(input string name, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input int mode,
                      input logic [31:0] cexp);
      sb_t e;
      step();
      cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
      drive_edge = edge_cnt;
      if (mode == 1) begin
         e.exp = cexp; e.chk4 = 1'b1; sb_q.push_back(e);
      end else if (mode == 2) begin
         e.exp = model_rd(a); e.chk4 = 1'b0; sb_q.push_back(e);
      end
      step();
      chk({name, "_ack"}, {63'd0, ack1}, 64'd1);
      cyc = 1'b0; we = 1'b0;
      if (mode != 0 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk({name, "_rdt"}, {32'd0, rdt1}, {32'd0, e.exp});
         if (e.chk4) chk({name, "_rdt4"}, {32'd0, rdt4}, {32'd0, e.exp});
      end
      $display("[TB] %s %s adr=0x%h dat=0x%h sel=%b rdt1=0x%h rdt4=0x%h",
               name, w ? "WR" : "RD", a, d, s, rdt1, rdt4);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tbl[0]  = '{1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 0, 32'h0};
      tbl[1]  = '{1'b0, 32'h8, 32'h0,         4'b0000, 1, 32'hFFBB_FFDD};
      tbl[2]  = '{1'b0, 32'hC, 32'h0,         4'b0000, 1, 32'hFFFF_FFFF};
      tbl[3]  = '{1'b1, 32'hC, 32'h0000_0005, 4'b1111, 0, 32'h0};
      tbl[4]  = '{1'b0, 32'hC, 32'h0,         4'b0000, 1, 32'h0000_0005};
      tbl[5]  = '{1'b1, 32'h8, 32'h0,         4'b1111, 0, 32'h0};
      tbl[6]  = '{1'b0, 32'h8, 32'h0,         4'b0000, 1, 32'h0};
      tbl[7]  = '{1'b0, 32'h4, 32'h0,         4'b0000, 1, 32'h0};
      tbl[8]  = '{1'b0, 32'h0, 32'h0,         4'b0000, 2, 32'h0};
      tbl[9]  = '{1'b1, 32'h8, 32'h1122_3344, 4'b0000, 0, 32'h0};
      tbl[10] = '{1'b0, 32'h8, 32'h0,         4'b0000, 1, 32'h0};

      rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0; prev_ack = 1'b0;
      repeat (3) step();
      chk("rst_ack1", {63'd0, ack1}, 64'd0);
      chk("rst_rdt1", {32'd0, rdt1}, 64'd0);
      chk("rst_irq1", {63'd0, irq1}, 64'd0);
      chk("rst_ack4", {63'd0, ack4}, 64'd0);
      chk("rst_rdt4", {32'd0, rdt4}, 64'd0);
      chk("rst_irq4", {63'd0, irq4}, 64'd0);
      rst_n = 1'b1;

      // Free-running count after reset release
      repeat (10) step();
      bus("rd_mtime_10", 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0);
      chk("mtime1_count", {32'd0, rdt1}, 64'(drive_edge));
      chk("mtime4_count", {32'd0, rdt4}, 64'(drive_edge / 4));
      chk("irq_low_10", {63'd0, irq1}, 64'd0);

      for (int i = 0; i < 11; i++) begin
         bus($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr, tbl[i].dat, tbl[i].sel,
             tbl[i].mode, tbl[i].exp);
      end

      // mtimecmp = 5_00000000: irq rises one edge after mtime reaches it
      bus("wr_mtime_hi4", 1'b1, 32'h4, 32'h0000_0004, 4'hF, 0, 32'h0);
      bus("wr_mtime_lo", 1'b1, 32'h0, 32'hFFFF_FFF0, 4'hF, 0, 32'h0);
      n = 0;
      while (!irq1 && n < 40) begin
         step();
         n++;
      end
      chk("irq_rise_delay", 64'(n), 64'd17);
      bus("rd_hi_after_carry", 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h0);

      // Carry from the low word into the high word
      bus("wr_mtime_hi0", 1'b1, 32'h4, 32'h0, 4'hF, 0, 32'h0);
      bus("wr_mtime_lo_fffe", 1'b1, 32'h0, 32'hFFFF_FFFE, 4'hF, 0, 32'h0);
      step();
      bus("rd_hi_carry", 1'b0, 32'h4, 32'h0, 4'h0, 2, 32'h0);
      chk("hi_carry_val", {32'd0, rdt1}, 64'd1);
      bus("rd_lo_small", 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0);
      chk("lo_small", {63'd0, rdt1 < 32'd16}, 64'd1);

      // Partial write while counting: byte 2 written, the rest keeps incrementing
      bus("wr_lo_byte2", 1'b1, 32'h0, 32'h00AB_0000, 4'b0100, 0, 32'h0);
      bus("rd_lo_byte2", 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0);
      chk("lo_byte2_val", {56'd0, rdt1[23:16]}, 64'hAB);

      // cyc held high: acks alternate, then reset lands on an ack cycle
      step();
      cyc = 1'b1; we = 1'b0; adr = 32'h8;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("ack_pat%0d", i), {63'd0, ack1}, 64'(i % 2));
         if (i < 5) step();
      end
      rst_n = 1'b0; we = 1'b1; adr = 32'h8; dat = 32'h0; sel = 4'hF;
      step();
      chk("rst_on_ack_ack1", {63'd0, ack1}, 64'd0);
      chk("rst_on_ack_ack4", {63'd0, ack4}, 64'd0);
      chk("rst_on_ack_rdt", {32'd0, rdt1}, 64'd0);
      chk("rst_on_ack_irq", {63'd0, irq1}, 64'd0);
      step();
      rst_n = 1'b1; cyc = 1'b0; we = 1'b0;

      // First access after release; the write sampled with reset must be gone
      bus("rd_cmp_lo_rst", 1'b0, 32'h8, 32'h0, 4'h0, 1, 32'hFFFF_FFFF);

      // DIV=4: mtimecmp = 3 -> irq4 rises at the 13th edge after release
      bus("wr_cmp_hi0", 1'b1, 32'hC, 32'h0, 4'hF, 0, 32'h0);
      bus("wr_cmp_lo3", 1'b1, 32'h8, 32'h3, 4'hF, 0, 32'h0);
      n = 0;
      while (!irq4 && n < 40) begin
         step();
         n++;
      end
      chk("irq4_rise_edge", 64'(edge_cnt), 64'd13);
      bus("rd_mtime_post_rst", 1'b0, 32'h0, 32'h0, 4'h0, 2, 32'h0);
      chk("mtime1_post_rst", {32'd0, rdt1}, 64'(drive_edge));
      chk("mtime4_post_rst", {32'd0, rdt4}, 64'(drive_edge / 4));

      // Raising mtimecmp above mtime drops the irq within two cycles
      bus("wr_cmp_hi1", 1'b1, 32'hC, 32'h1, 4'hF, 0, 32'h0);
      step();
      step();
      chk("irq4_fall", {63'd0, irq4}, 64'd0);
      chk("irq1_fall", {63'd0, irq1}, 64'd0);
      bus("rd_cmp_hi1", 1'b0, 32'hC, 32'h0, 4'h0, 1, 32'h1);

      chk("sb_empty", 64'(sb_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
